mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-port simulation memory between two requesters: instruction fetch (port I) and load/store (port D).
- Sits between the CPU core and the memory. It drives the memory's addr, data, rd, wr and en inputs and samples its tri-state out bus.
- Provides a req/ack handshake per port and round-robin arbitration.
- Supports a programmable number of wait states so the core can be exercised against slow memory.

Parameters:
- WORD_SIZE, 32, data width of memory and requester ports.
- ADDR_WIDTH, 16, address width.
- WAIT_CYCLES, 0, extra cycles the memory controls are held before completion (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  fetch request; held high until i_ack is sampled.
- i_addr  input  ADDR_WIDTH  fetch address; stable while i_req is high.
- i_ack  output  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  output  WORD_SIZE  fetched word.
- d_req  input  1  data request; held high until d_ack is sampled.
- d_we  input  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  input  ADDR_WIDTH  data address.
- d_wdata  input  WORD_SIZE  write data.
- d_ack  output  1  one-cycle completion pulse.
- d_rdata  output  WORD_SIZE  read word; holds its value for writes.
- mem_addr  output  ADDR_WIDTH  to memory addr.
- mem_data  output  WORD_SIZE  to memory data.
- mem_rd  output  1  to memory rd.
- mem_wr  output  1  to memory wr.
- mem_en  output  1  to memory en.
- mem_out  input  WORD_SIZE  from memory out; high-Z when not read-enabled.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, wait counter=0, last_grant=I.
  - All ack, mem_rd, mem_wr and mem_en outputs = 0.
  - mem_addr, mem_data, i_rdata and d_rdata = 0.
- Reset mid-access aborts the access immediately. No ack is issued, and no write occurs after reset is asserted.
- IDLE:
  - Samples i_req and d_req on each rising edge.
  - Only one asserted: grant that port.
  - Both asserted: grant the port that is not last_grant. With last_grant=I after reset, D wins the first tie.
  - On grant: latch addr, we and wdata into registered mem_* outputs, load counter=WAIT_CYCLES, update last_grant, go to ACCESS.
  - Port I is always a read.
- ACCESS:
  - mem_en=1. mem_rd=1 for reads.
  - mem_addr and mem_data are held stable for WAIT_CYCLES+1 cycles.
  - counter!=0: decrement and stay.
  - counter==0:
    - Write: mem_wr=1 for this cycle only, so exactly one memory write edge.
    - Read: capture mem_out into the granted port's rdata register at the end of this cycle.
    - Go to RESP.
- RESP:
  - All mem_* strobes = 0.
  - The granted port's ack=1 for exactly one cycle.
  - rdata is valid and holds until that port's next read completes.
  - req inputs are ignored in this state, so a request the requester has not yet dropped is never re-granted.
  - Go to IDLE.
- Latency: req high at edge k gives ack high in cycle k+WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+3 cycles.
- mem_out must never be sampled while mem_rd=0 or mem_en=0, because the bus is high-Z then.
- A req that drops before ack is a protocol violation. The access still completes.
- Simultaneous new req on the losing port while the other is in ACCESS: the waiting port is granted at the next IDLE. Round-robin guarantees it wins before the other port is served again.
- Counter width is 4 bits. WAIT_CYCLES > 15 is illegal (elaboration assertion).

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - port enum {PORT_I, PORT_D}.
  - Wait counter width constant.
- One sub-module, mem_arb_rr: 2-way round-robin picker.
  - Inputs: two requests and last_grant.
  - Outputs: grant valid and winning port index.
  - Purely combinational; last_grant is stored in the parent.

Test Plan:
- Reset then i_req=1, i_addr=0x0004, mem[4]=0xDEADBEEF, WAIT_CYCLES=0 -> mem_rd=en=1 for 1 cycle, i_ack pulses 2 cycles after grant edge with i_rdata=0xDEADBEEF; d_ack stays 0.
- d_req=1, d_we=1, d_addr=0x0010, d_wdata=0x12345678 -> mem_wr high exactly one cycle, d_ack once, subsequent I read of 0x0010 returns 0x12345678.
- i_req and d_req both held high continuously -> grants alternate D,I,D,I; 4 acks in 4*(WAIT_CYCLES+3) cycles; no port starves.
- WAIT_CYCLES=3, D read of 0x0020=0xA5A5A5A5 -> mem_addr stable for 4 ACCESS cycles, d_ack at k+5, d_rdata=0xA5A5A5A5.
- Requester keeps i_req high through the cycle after i_ack -> no duplicate grant in RESP; second access starts only from IDLE and yields a second distinct i_ack.
- rst_n pulsed low during ACCESS of a write with WAIT_CYCLES=3 -> all strobes 0 asynchronously, memory location unchanged, no ack, state IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: controller states, requester port
// identifiers and the wait-state counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned WAIT_MAX   = (1 << WAIT_CNT_W) - 1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   ireq_i       - instruction-fetch request
//   dreq_i       - load/store request
//   last_grant_i - port granted most recently (held by the parent)
//   valid_o      - at least one request present
//   port_o       - winning port
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic  ireq_i,
  input  logic  dreq_i,
  input  port_e last_grant_i,
  output logic  valid_o,
  output port_e port_o
);

  always_comb begin
    valid_o = ireq_i | dreq_i;
    port_o  = PORT_I;
    if (ireq_i && dreq_i) begin
      // On a tie the port that did not win last time goes first.
      port_o = (last_grant_i == PORT_I) ? PORT_D : PORT_I;
    end else if (dreq_i) begin
      port_o = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between instruction fetch (I) and load/store
// (D) with a req/ack handshake per port, round-robin arbitration and a
// programmable number of wait states.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   i_req/i_addr/i_ack/i_rdata  - fetch port (read only)
//   d_req/d_we/d_addr/d_wdata   - load/store request
//   d_ack/d_rdata               - load/store completion and read word
//   mem_addr/mem_data           - registered address / write data to memory
//   mem_rd/mem_wr/mem_en        - memory strobes
//   mem_out                     - memory read bus (high-Z unless read-enabled)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [WORD_SIZE-1:0]  i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_ack,
  output logic [WORD_SIZE-1:0]  d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_data,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_en,
  input  logic [WORD_SIZE-1:0]  mem_out
);

  if (WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("mem_arbiter: WAIT_CYCLES must be in 0..15");
  end

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  port_e                   last_q, last_d;
  port_e                   gnt_q, gnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]    irdata_q, irdata_d;
  logic [WORD_SIZE-1:0]    drdata_q, drdata_d;

  logic  rr_valid;
  port_e rr_port;

  mem_arb_rr u_rr (
    .ireq_i       (i_req),
    .dreq_i       (d_req),
    .last_grant_i (last_q),
    .valid_o      (rr_valid),
    .port_o       (rr_port)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= PORT_I;
      gnt_q    <= PORT_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops them at once and mem_wr can only be high in the final
    // ACCESS cycle.
    mem_en = (state_q == ACCESS);
    mem_rd = (state_q == ACCESS) && !we_q;
    mem_wr = (state_q == ACCESS) && we_q && (cnt_q == '0);
    i_ack  = (state_q == RESP) && (gnt_q == PORT_I);
    d_ack  = (state_q == RESP) && (gnt_q == PORT_D);

    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          gnt_d   = rr_port;
          last_d  = rr_port;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
          if (rr_port == PORT_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            addr_d  = i_addr;
            we_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // mem_out is only driven while rd and en are both high, which is
          // exactly this read cycle.
          if (!we_q) begin
            if (gnt_q == PORT_I) irdata_d = mem_out;
            else                 drdata_d = mem_out;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        // Requests are ignored here so a req that is still high is only
        // re-arbitrated from IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_data = wdata_q;
  assign i_rdata  = irdata_q;
  assign d_rdata  = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 runs with WAIT_CYCLES=0, instance 1 with
// WAIT_CYCLES=3, each attached to its own behavioural single-port memory.
module tb_mem_arbiter;

  localparam int WS = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   [2];
  logic          i_req   [2];
  logic [AW-1:0] i_addr  [2];
  logic          i_ack   [2];
  logic [WS-1:0] i_rdata [2];
  logic          d_req   [2];
  logic          d_we    [2];
  logic [AW-1:0] d_addr  [2];
  logic [WS-1:0] d_wdata [2];
  logic          d_ack   [2];
  logic [WS-1:0] d_rdata [2];
  logic [AW-1:0] mem_addr[2];
  logic [WS-1:0] mem_data[2];
  logic          mem_rd  [2];
  logic          mem_wr  [2];
  logic          mem_en  [2];

  logic [WS-1:0] ref_mem [2][65536];
  logic [WS-1:0] d_last  [2];
  int            wr_exp  [2];
  int            en_cyc  [2];
  int            rd_cyc  [2];
  int            wr_cyc  [2];
  logic          prev_en [2];
  logic [AW-1:0] prev_addr[2];
  logic [WS-1:0] prev_data[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rec = 1'b0;
  int ord[$];
  logic [WS-1:0] q0[$], q1[$], q2[$], q3[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WS-1:0] pat(input int g, input int a);
    if (a == 4)     return 32'hDEADBEEF;
    if (a == 'h20)  return 32'hA5A5A5A5;
    return 32'(a) * 32'h9E3779B1 + 32'(g);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [WS-1:0] mem [65536];
    wire  [WS-1:0] bus;

    initial for (int a = 0; a < 65536; a++) mem[a] = pat(g, a);

    assign bus = (mem_en[g] && mem_rd[g]) ? mem[mem_addr[g]] : {WS{1'bz}};

    always @(posedge clk)
      if (mem_en[g] && mem_wr[g]) mem[mem_addr[g]] <= mem_data[g];

    mem_arbiter #(
      .WORD_SIZE  (WS),
      .ADDR_WIDTH (AW),
      .WAIT_CYCLES(g == 0 ? 0 : 3)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .i_req   (i_req[g]),
      .i_addr  (i_addr[g]),
      .i_ack   (i_ack[g]),
      .i_rdata (i_rdata[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we[g]),
      .d_addr  (d_addr[g]),
      .d_wdata (d_wdata[g]),
      .d_ack   (d_ack[g]),
      .d_rdata (d_rdata[g]),
      .mem_addr(mem_addr[g]),
      .mem_data(mem_data[g]),
      .mem_rd  (mem_rd[g]),
      .mem_wr  (mem_wr[g]),
      .mem_en  (mem_en[g]),
      .mem_out (bus)
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard key: k = 2*instance + port (0 = I, 1 = D).
  task automatic sb_push(input int k, input logic [WS-1:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      2:       q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic sb_check(input int k, input logic [WS-1:0] act);
    int sz;
    logic [WS-1:0] e;
    e = '0;
    case (k)
      0:       sz = q0.size();
      1:       sz = q1.size();
      2:       sz = q2.size();
      default: sz = q3.size();
    endcase
    chk($sformatf("ack_expected k%0d", k), 64'(sz != 0), 64'd1);
    if (sz != 0) begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        2:       e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      chk($sformatf("rdata k%0d", k), 64'(act), 64'(e));
    end
  endtask

  // Monitor: pops the scoreboard on every ack and watches the memory bus.
  initial begin
    for (int g = 0; g < 2; g++) begin
      en_cyc[g] = 0; rd_cyc[g] = 0; wr_cyc[g] = 0; prev_en[g] = 1'b0;
      prev_addr[g] = '0; prev_data[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (mem_en[g]) en_cyc[g]++;
        if (mem_rd[g]) rd_cyc[g]++;
        if (mem_wr[g]) wr_cyc[g]++;
        if (mem_en[g] && prev_en[g])
          chk($sformatf("addr_data_stable g%0d", g), 64'({mem_addr[g], mem_data[g]}),
              64'({prev_addr[g], prev_data[g]}));
        prev_en[g]   = mem_en[g];
        prev_addr[g] = mem_addr[g];
        prev_data[g] = mem_data[g];
        if (i_ack[g]) begin
          sb_check(2 * g, i_rdata[g]);
          if (rec && g == 0) ord.push_back(0);
        end
        if (d_ack[g]) begin
          sb_check(2 * g + 1, d_rdata[g]);
          if (rec && g == 0) ord.push_back(1);
        end
      end
    end
  end

  // Waits for the port's ack; lat is the expected number of falling edges
  // from the request being driven to the ack (negative: not checked).
  task automatic wait_ack(input int g, input int port, input int lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = (port == 0) ? i_ack[g] : d_ack[g];
    end
    chk($sformatf("ack_timeout g%0d p%0d", g, port), 64'(got), 64'd1);
    if (got && lat >= 0)
      chk($sformatf("latency g%0d p%0d", g, port), 64'(n), 64'(lat));
  endtask

  task automatic do_i(input int g, input logic [AW-1:0] a, input bit keep, input int lat);
    i_addr[g] = a;
    i_req[g]  = 1'b1;
    sb_push(2 * g, ref_mem[g][a]);
    wait_ack(g, 0, lat);
    @(posedge clk); #1;
    if (!keep) i_req[g] = 1'b0;
  endtask

  task automatic do_d(input int g, input logic [AW-1:0] a, input bit we,
                      input logic [WS-1:0] wd, input bit keep, input int lat);
    d_addr[g]  = a;
    d_we[g]    = we;
    d_wdata[g] = wd;
    d_req[g]   = 1'b1;
    if (we) begin
      ref_mem[g][a] = wd;
      wr_exp[g]++;
    end else begin
      d_last[g] = ref_mem[g][a];
    end
    sb_push(2 * g + 1, d_last[g]);
    wait_ack(g, 1, lat);
    @(posedge clk); #1;
    if (!keep) d_req[g] = 1'b0;
  endtask

  task automatic rand_i(input int g, input int n);
    for (int t = 0; t < n; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      do_i(g, 16'($urandom_range(0, 'h0FFF)), 1'b0, -1);
    end
  endtask

  task automatic rand_d(input int g, input int n);
    for (int t = 0; t < n; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      do_d(g, 16'h1000 + 16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
           32'($urandom()), 1'b0, -1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, w0, c0, code, mm;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; i_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0;
      i_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
      d_last[g] = '0; wr_exp[g] = 0;
      for (int a = 0; a < 65536; a++) ref_mem[g][a] = pat(g, a);
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_strobes g%0d", g),
          64'({i_ack[g], d_ack[g], mem_rd[g], mem_wr[g], mem_en[g]}), 64'd0);
      chk($sformatf("rst_addr_data g%0d", g), 64'({mem_addr[g], mem_data[g]}), 64'd0);
      chk($sformatf("rst_rdata g%0d", g), 64'({i_rdata[g], d_rdata[g]}), 64'd0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // WAIT_CYCLES=0: fetch from 0x0004
    e0 = en_cyc[0]; r0 = rd_cyc[0];
    do_i(0, 16'h0004, 1'b0, 3);
    chk("g0_fetch_en_cycles", 64'(en_cyc[0] - e0), 64'd1);
    chk("g0_fetch_rd_cycles", 64'(rd_cyc[0] - r0), 64'd1);

    // WAIT_CYCLES=0: store then fetch the stored word
    e0 = en_cyc[0]; w0 = wr_cyc[0];
    do_d(0, 16'h0010, 1'b1, 32'h12345678, 1'b0, 3);
    chk("g0_store_wr_cycles", 64'(wr_cyc[0] - w0), 64'd1);
    chk("g0_store_en_cycles", 64'(en_cyc[0] - e0), 64'd1);
    chk("g0_store_mem", 64'(g_dut[0].mem[16'h0010]), 64'h12345678);
    do_i(0, 16'h0010, 1'b0, 3);

    // Both ports requesting continuously: D,I,D,I in 4*(0+3) cycles
    ord.delete();
    rec = 1'b1;
    c0 = cyc;
    fork
      begin
        do_d(0, 16'h1100, 1'b0, 32'h0, 1'b1, -1);
        do_d(0, 16'h1104, 1'b1, 32'hC0FFEE11, 1'b0, -1);
      end
      begin
        do_i(0, 16'h0200, 1'b1, -1);
        do_i(0, 16'h0204, 1'b0, -1);
      end
    join
    rec = 1'b0;
    chk("g0_rr_elapsed", 64'(cyc - c0), 64'd12);
    code = 0;
    foreach (ord[i]) code = code * 2 + ord[i];
    chk("g0_rr_ack_count", 64'(ord.size()), 64'd4);
    chk("g0_rr_order", 64'(code), 64'b1010);

    // WAIT_CYCLES=3: load from 0x0020
    e0 = en_cyc[1];
    do_d(1, 16'h0020, 1'b0, 32'h0, 1'b0, 6);
    chk("g1_load_en_cycles", 64'(en_cyc[1] - e0), 64'd4);

    // Fetch req left high through the cycle after ack: two separate accesses
    c0 = cyc;
    do_i(1, 16'h0100, 1'b1, 6);
    do_i(1, 16'h0104, 1'b0, 6);
    chk("g1_held_req_elapsed", 64'(cyc - c0), 64'd12);

    // Reset in the middle of a write access
    w0 = wr_cyc[1];
    d_addr[1] = 16'h0030; d_we[1] = 1'b1; d_wdata[1] = 32'hCAFEF00D; d_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("g1_abort_strobes", 64'({d_ack[1], mem_rd[1], mem_wr[1], mem_en[1]}), 64'd0);
    d_req[1] = 1'b0;
    d_we[1]  = 1'b0;
    d_last[1] = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    chk("g1_abort_no_write", 64'(wr_cyc[1] - w0), 64'd0);
    chk("g1_abort_mem", 64'(g_dut[1].mem[16'h0030]), 64'(ref_mem[1][16'h0030]));
    do_d(1, 16'h0030, 1'b0, 32'h0, 1'b0, 6);

    // Randomised traffic on both instances
    fork
      rand_i(0, 25);
      rand_d(0, 25);
      rand_i(1, 25);
      rand_d(1, 25);
    join
    repeat (8) @(posedge clk);

    chk("sb_drained", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);
    chk("g0_write_count", 64'(wr_cyc[0]), 64'(wr_exp[0]));
    chk("g1_write_count", 64'(wr_cyc[1]), 64'(wr_exp[1]));
    mm = 0;
    for (int a = 0; a < 65536; a++) begin
      if (g_dut[0].mem[a] !== ref_mem[0][a]) mm++;
      if (g_dut[1].mem[a] !== ref_mem[1][a]) mm++;
    end
    chk("mem_image", 64'(mm), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
